// File: rtl/mips_pkg.sv
// mips_pkg: shared register-file widths, write-request type and helpers
package mips_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int NUM_REGS   = 1 << REG_ADDR_W;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_W-1:0]     data;
    } wb_req_t;

    function automatic logic [NUM_REGS-1:0] rd_onehot(input logic [REG_ADDR_W-1:0] rd);
        return NUM_REGS'(1) << rd;
    endfunction
endpackage

// File: rtl/wb_result_fifo.sv
// wb_result_fifo: circular buffer of queued MDU write requests with a flat entry view
module wb_result_fifo
    import mips_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  wb_req_t                push_req,
    input  logic                   pop,
    output logic                   full,
    output logic                   empty,
    output wb_req_t                head,
    output logic [$clog2(DEPTH):0] count,
    output wb_req_t [DEPTH-1:0]    entries,
    output logic [DEPTH-1:0]       valid
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] wr_ptr, rd_ptr;

    assign full  = count == CW'(DEPTH);
    assign empty = count == '0;
    assign head  = entries[rd_ptr];

    // pointers, occupancy and per-slot valid bits; pointers wrap naturally at the power-of-2 depth
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            valid  <= '0;
        end else begin
            if (pop) begin
                rd_ptr         <= rd_ptr + PW'(1);
                valid[rd_ptr]  <= 1'b0;
            end
            if (push) begin
                wr_ptr         <= wr_ptr + PW'(1);
                valid[wr_ptr]  <= 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // payload storage needs no reset: slot contents only matter while valid
    always_ff @(posedge clk) begin
        if (push) entries[wr_ptr] <= push_req;
    end
endmodule

// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter: merges in-order pipeline results and queued MDU results onto the regfile write port
module wb_write_arbiter
    import mips_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pipe_valid,
    input  logic                  pipe_regwrite,
    input  logic [REG_ADDR_W-1:0] pipe_rd,
    input  logic [DATA_W-1:0]     pipe_data,
    input  logic                  mdu_valid,
    output logic                  mdu_ready,
    input  logic [REG_ADDR_W-1:0] mdu_rd,
    input  logic [DATA_W-1:0]     mdu_data,
    output logic                  wb_regwrite,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic [DATA_W-1:0]     wb_writedata,
    output logic [NUM_REGS-1:0]   pending_mask,
    output logic                  stall_req,
    output logic                  protocol_err
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int SW = $clog2(STARVE_LIMIT) + 1;

    logic                      pipe_wr, push, pop, full, empty;
    logic [CW-1:0]             count;
    wb_req_t                   head;
    wb_req_t [FIFO_DEPTH-1:0]  entries;
    logic [FIFO_DEPTH-1:0]     valid;
    logic [SW-1:0]             starve_cnt;

    assign pipe_wr   = pipe_valid & pipe_regwrite & (pipe_rd != REG_ZERO);
    assign mdu_ready = count < CW'(FIFO_DEPTH);
    assign push      = mdu_valid & ~full & (mdu_rd != REG_ZERO);
    assign pop       = ~pipe_wr & ~empty;

    wb_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_req ('{rd: mdu_rd, data: mdu_data}),
        .pop      (pop),
        .full     (full),
        .empty    (empty),
        .head     (head),
        .count    (count),
        .entries  (entries),
        .valid    (valid)
    );

    // destinations still sitting in the queue, for the decode hazard check
    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < FIFO_DEPTH; i++)
            if (valid[i]) pending_mask |= rd_onehot(entries[i].rd);
    end

    // fixed-priority grant of the single write port: pipeline first, then queue head
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_regwrite  <= 1'b0;
            wb_rd        <= '0;
            wb_writedata <= '0;
        end else if (pipe_wr) begin
            wb_regwrite  <= 1'b1;
            wb_rd        <= pipe_rd;
            wb_writedata <= pipe_data;
        end else if (pop) begin
            wb_regwrite  <= 1'b1;
            wb_rd        <= head.rd;
            wb_writedata <= head.data;
        end else begin
            wb_regwrite  <= 1'b0;
        end
    end

    // count how long the head has been starved and ask for bubbles once the limit is hit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
            stall_req  <= 1'b0;
        end else begin
            stall_req  <= (starve_cnt >= SW'(STARVE_LIMIT - 1)) & ~empty & ~pop;
            starve_cnt <= (empty | pop) ? '0 :
                          (starve_cnt == SW'(STARVE_LIMIT - 1)) ? starve_cnt : starve_cnt + SW'(1);
        end
    end

    // sticky flag for pipeline writes that break the stall or WAW contract
    always_ff @(posedge clk or posedge rst) begin
        if (rst) protocol_err <= 1'b0;
        else if (pipe_wr & (stall_req | pending_mask[pipe_rd])) protocol_err <= 1'b1;
    end
endmodule

// File: tb/tb_wb_write_arbiter.sv
// tb_wb_write_arbiter: randomized and directed checks against a queue-based reference model
module tb_wb_write_arbiter;
    import mips_pkg::*;

    localparam int DEPTH = 4;
    localparam int LIMIT = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pipe_valid = 0, pipe_regwrite = 0, mdu_valid = 0;
    logic [4:0]  pipe_rd = 0, mdu_rd = 0;
    logic [31:0] pipe_data = 0, mdu_data = 0;
    logic        mdu_ready, wb_regwrite, stall_req, protocol_err;
    logic [4:0]  wb_rd;
    logic [31:0] wb_writedata, pending_mask;

    always #5 clk = ~clk;

    wb_write_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk           (clk),
        .rst           (rst),
        .pipe_valid    (pipe_valid),
        .pipe_regwrite (pipe_regwrite),
        .pipe_rd       (pipe_rd),
        .pipe_data     (pipe_data),
        .mdu_valid     (mdu_valid),
        .mdu_ready     (mdu_ready),
        .mdu_rd        (mdu_rd),
        .mdu_data      (mdu_data),
        .wb_regwrite   (wb_regwrite),
        .wb_rd         (wb_rd),
        .wb_writedata  (wb_writedata),
        .pending_mask  (pending_mask),
        .stall_req     (stall_req),
        .protocol_err  (protocol_err)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        q[$];
    logic        m_rw, m_stall, m_err;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    int          m_wait;
    int          n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [31:0] m_mask();
        logic [31:0] m = '0;
        foreach (q[i]) m[q[i].rd] = 1'b1;
        return m;
    endfunction

    task automatic model_reset();
        q.delete();
        m_rw = 0; m_rd = 0; m_data = 0; m_stall = 0; m_err = 0; m_wait = 0;
    endtask

    task automatic check_all(input string t);
        chk({t, "_regwrite"}, wb_regwrite, m_rw);
        chk({t, "_rd"}, wb_rd, m_rd);
        chk({t, "_data"}, wb_writedata, m_data);
        chk({t, "_ready"}, mdu_ready, q.size() < DEPTH);
        chk({t, "_mask"}, pending_mask, m_mask());
        chk({t, "_stall"}, stall_req, m_stall);
        chk({t, "_err"}, protocol_err, m_err);
    endtask

    // apply one cycle of inputs (called at a negedge), advance the model, check after the edge
    task automatic cycle(input string t, input logic pv, input logic prw, input logic [4:0] prd,
                         input logic [31:0] pd, input logic mv, input logic [4:0] mrd, input logic [31:0] md);
        logic [31:0] mask;
        logic        pw, acc, pop, busy;
        ent_t        h;
        pipe_valid = pv; pipe_regwrite = prw; pipe_rd = prd; pipe_data = pd;
        mdu_valid = mv; mdu_rd = mrd; mdu_data = md;
        mask = m_mask();
        pw   = pv && prw && prd != 0;
        acc  = mv && q.size() < DEPTH;
        busy = q.size() > 0;
        pop  = !pw && busy;
        if (pw && (m_stall || mask[prd])) m_err = 1;
        if (pw) begin
            m_rw = 1; m_rd = prd; m_data = pd;
        end else if (pop) begin
            h = q.pop_front();
            m_rw = 1; m_rd = h.rd; m_data = h.data;
        end else m_rw = 0;
        m_stall = busy && !pop && m_wait >= LIMIT - 1;
        m_wait  = (busy && !pop) ? m_wait + 1 : 0;
        if (acc && mrd != 0) q.push_back('{mrd, md});
        @(posedge clk);
        @(negedge clk);
        check_all(t);
    endtask

    task automatic idle(input string t, input int n);
        for (int i = 0; i < n; i++) cycle(t, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst = 1;
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        model_reset();
        check_all("reset");
    endtask

    initial begin
        int n;
        logic [31:0] mk;
        logic [4:0]  prd;
        model_reset();
        #12;
        check_all("por");
        @(negedge clk);
        rst = 0;

        // legal random traffic: no writes during stall, no WAW on pending registers
        for (int i = 0; i < 400; i++) begin
            mk  = m_mask();
            prd = 5'($urandom_range(0, 31));
            if (mk[prd]) prd = 0;
            cycle("rand", !m_stall && $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 9, prd, $urandom,
                  $urandom_range(0, 9) < 6, 5'($urandom_range(0, 31)), $urandom);
        end
        chk("rand_err_clean", protocol_err, 0);
        idle("drain", 6);

        // T1
        cycle("t1", 1, 1, 5, 32'hAD654321, 0, 0, 0);
        chk("t1_rd", wb_rd, 5);
        chk("t1_data", wb_writedata, 32'hAD654321);

        // T2
        cycle("t2_rd0", 1, 1, 0, 32'h1234, 0, 0, 0);
        chk("t2_rd0_rw", wb_regwrite, 0);
        cycle("t2_q", 1, 1, 3, 32'h33, 1, 6, 32'h66);
        cycle("t2_pop", 1, 1, 0, 32'h99, 0, 0, 0);
        chk("t2_pop_rd", wb_rd, 6);

        // T3
        for (int i = 1; i <= 4; i++) cycle("t3_fill", 1, 1, 5'(20 + i), 32'(i), 1, 5'(i), 32'(100 + i));
        chk("t3_ready", mdu_ready, 0);
        chk("t3_mask", pending_mask, 32'h1E);
        cycle("t3_full", 1, 1, 25, 0, 1, 5, 32'h5555);
        for (int i = 1; i <= 4; i++) begin
            cycle("t3_drain", 0, 0, 0, 0, 0, 0, 0);
            chk("t3_order", wb_rd, 5'(i));
        end
        chk("t3_mask0", pending_mask, 0);
        idle("t3_end", 1);
        chk("t3_nodrop", wb_regwrite, 0);

        // T4
        cycle("t4_q", 1, 1, 3, 0, 1, 9, 32'h9);
        n = 0;
        while (n < 20 && !stall_req) begin
            cycle("t4_wait", 1, 1, 3, 32'(n), 0, 0, 0);
            n++;
        end
        chk("t4_wait_cycles", n, 8);
        idle("t4_release", 1);
        chk("t4_pop_rd", wb_rd, 9);
        idle("t4_after", 1);

        // T5
        for (int i = 0; i < 3; i++) cycle("t5_fill", 1, 1, 2, 0, 1, 5'(10 + i), 32'(i));
        pipe_valid = 0; mdu_valid = 0;
        #2 rst = 1;
        #1;
        chk("t5_async_rw", wb_regwrite, 0);
        chk("t5_async_mask", pending_mask, 0);
        chk("t5_async_ready", mdu_ready, 1);
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        model_reset();
        check_all("t5_rel");
        idle("t5_empty", 4);

        // T6
        cycle("t6_q", 1, 1, 2, 0, 1, 7, 32'h77);
        cycle("t6_waw", 1, 1, 7, 32'hBEEF, 0, 0, 0);
        chk("t6_err", protocol_err, 1);
        chk("t6_granted", wb_writedata, 32'hBEEF);
        idle("t6_sticky", 4);
        do_reset();

        // protocol error from writing through an active stall
        cycle("t7_q", 1, 1, 3, 0, 1, 9, 0);
        n = 0;
        while (n < 20 && !stall_req) begin
            cycle("t7_wait", 1, 1, 3, 0, 0, 0, 0);
            n++;
        end
        cycle("t7_viol", 1, 1, 4, 32'h44, 0, 0, 0);
        chk("t7_err", protocol_err, 1);
        idle("t7_drain", 3);
        do_reset();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end
endmodule
